// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle LEGv8 sequencer: controller state
// encoding, opcode match constants, ALU operation codes, sign-extender
// formats and the instruction-class vector produced by the opcode decoder.
package mc_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      MEMORY,
      WRITEBACK
   } state_t;

   // Full 11-bit opcodes
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;
   // Short opcodes compared against the top bits only; the ADDI/SUBI values
   // correspond to 11-bit patterns 488/489 and 688/689.
   localparam logic [9:0]  OP_ADDI = 10'h244;   // opcode[10:1]
   localparam logic [9:0]  OP_SUBI = 10'h344;   // opcode[10:1]
   localparam logic [7:0]  OP_CBZ  = 8'hB4;     // opcode[10:3]
   localparam logic [5:0]  OP_B    = 6'h05;     // opcode[10:5]

   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [2:0] SIGN_I  = 3'b000;
   localparam logic [2:0] SIGN_D  = 3'b001;
   localparam logic [2:0] SIGN_B  = 3'b010;
   localparam logic [2:0] SIGN_CB = 3'b011;

   // One-hot instruction class; all-zero means illegal
   typedef struct packed {
      logic ldur;
      logic stur;
      logic rtype;
      logic addi;
      logic subi;
      logic cbz;
      logic b;
   } cls_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory handshake between the sequencer (master) and the shared
// instruction/data memory (slave).
//   mem_req   : access request
//   mem_we    : access is a write
//   iord      : address source, 0 = PC, 1 = ALU result register
//   mem_ready : acknowledge, completes the current access
interface multicycle_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer_decode.sv
// Combinational opcode classifier.
//   i_opcode  : instruction[31:21]
//   o_cls     : one-hot instruction class
//   o_aluctrl : ALU operation for the class (ADD for loads/stores)
//   o_illegal : no class matched
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [10:0] i_opcode,
   output cls_t        o_cls,
   output logic [3:0]  o_aluctrl,
   output logic        o_illegal
);

   always_comb begin
      o_cls     = '0;
      o_aluctrl = ALU_ADD;
      if (i_opcode == OP_LDUR) begin
         o_cls.ldur = 1'b1;
      end else if (i_opcode == OP_STUR) begin
         o_cls.stur = 1'b1;
      end else if (i_opcode == OP_ADD) begin
         o_cls.rtype = 1'b1;
      end else if (i_opcode == OP_SUB) begin
         o_cls.rtype = 1'b1;
         o_aluctrl   = ALU_SUB;
      end else if (i_opcode == OP_AND) begin
         o_cls.rtype = 1'b1;
         o_aluctrl   = ALU_AND;
      end else if (i_opcode == OP_ORR) begin
         o_cls.rtype = 1'b1;
         o_aluctrl   = ALU_ORR;
      end else if (i_opcode[10:1] == OP_ADDI) begin
         o_cls.addi = 1'b1;
      end else if (i_opcode[10:1] == OP_SUBI) begin
         o_cls.subi = 1'b1;
         o_aluctrl  = ALU_SUB;
      end else if (i_opcode[10:3] == OP_CBZ) begin
         o_cls.cbz = 1'b1;
         o_aluctrl = ALU_PASSB;
      end else if (i_opcode[10:5] == OP_B) begin
         o_cls.b = 1'b1;
      end
   end

   assign o_illegal = (o_cls == '0);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle LEGv8 controller: steps each instruction through FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK, stalls on memory acknowledge and counts
// retired instructions.
//   CLK, resetl        : clock, synchronous active-high reset
//   opcode, zero       : IR opcode field, ALU zero flag
//   mem                : memory handshake (mem_req, mem_we, iord, mem_ready)
//   ir_write..mem2reg  : datapath control strobes
//   retire, illegal    : one-cycle completion / undecodable-opcode pulses
//   instr_count        : retired-instruction count (wraps)
module multicycle_sequencer
   import mc_pkg::*;
(
   input  logic                          CLK,
   input  logic                          resetl,
   input  logic [10:0]                   opcode,
   input  logic                          zero,
   multicycle_sequencer_if.master        mem,
   output logic                          ir_write,
   output logic                          pc_write,
   output logic                          pc_src,
   output logic                          reg2loc,
   output logic                          alusrc,
   output logic [3:0]                    aluctrl,
   output logic [2:0]                    signop,
   output logic                          reg_write,
   output logic                          mem2reg,
   output logic                          retire,
   output logic                          illegal,
   output logic [31:0]                   instr_count
);

   state_t      r_state;
   logic [31:0] r_count;
   cls_t        w_cls;
   logic [3:0]  w_aluctrl;
   logic        w_illegal;
   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_iord;

   mc_opcode_decode u_decode (
      .i_opcode  (opcode),
      .o_cls     (w_cls),
      .o_aluctrl (w_aluctrl),
      .o_illegal (w_illegal)
   );

   always_ff @(posedge CLK) begin
      if (resetl) begin
         r_state <= FETCH;
         r_count <= '0;
      end else begin
         r_count <= r_count + {31'd0, retire};
         case (r_state)
            FETCH:     if (mem.mem_ready) r_state <= DECODE;
            DECODE:    r_state <= w_illegal ? FETCH : EXECUTE;
            EXECUTE: begin
               if (w_cls.ldur || w_cls.stur)   r_state <= MEMORY;
               else if (w_cls.cbz || w_cls.b)  r_state <= FETCH;
               else                            r_state <= WRITEBACK;
            end
            MEMORY:    if (mem.mem_ready) r_state <= w_cls.ldur ? WRITEBACK : FETCH;
            WRITEBACK: r_state <= FETCH;
            default:   r_state <= FETCH;
         endcase
      end
   end

   // Strobes decode the current state combinationally: the fetch-complete
   // and CBZ-taken strobes must land in the same cycle as mem_ready / zero.
   // Everything is held low while reset is asserted.
   always_comb begin
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_iord    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg2loc   = 1'b0;
      alusrc    = 1'b0;
      aluctrl   = '0;
      signop    = '0;
      reg_write = 1'b0;
      mem2reg   = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      if (!resetl) begin
         case (r_state)
            FETCH: begin
               w_mem_req = 1'b1;
               if (mem.mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            DECODE: illegal = w_illegal;
            EXECUTE: begin
               if (w_cls.rtype) aluctrl = w_aluctrl;
               if (w_cls.addi || w_cls.subi) begin
                  aluctrl = w_aluctrl;
                  alusrc  = 1'b1;
                  signop  = SIGN_I;
               end
               if (w_cls.ldur || w_cls.stur) begin
                  aluctrl = w_aluctrl;
                  alusrc  = 1'b1;
                  signop  = SIGN_D;
                  reg2loc = w_cls.stur;
               end
               if (w_cls.cbz) begin
                  reg2loc  = 1'b1;
                  aluctrl  = w_aluctrl;
                  signop   = SIGN_CB;
                  pc_write = zero;
                  pc_src   = zero;
                  retire   = 1'b1;
               end
               if (w_cls.b) begin
                  signop   = SIGN_B;
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
                  retire   = 1'b1;
               end
            end
            MEMORY: begin
               w_mem_req = 1'b1;
               w_iord    = 1'b1;
               w_mem_we  = w_cls.stur;
               retire    = w_cls.stur && mem.mem_ready;
            end
            WRITEBACK: begin
               reg_write = 1'b1;
               mem2reg   = w_cls.ldur;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_req = w_mem_req;
   assign mem.mem_we  = w_mem_we;
   assign mem.iord    = w_iord;
   assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg2loc;
      logic       alusrc;
      logic [3:0] aluctrl;
      logic [2:0] signop;
      logic       reg_write;
      logic       mem2reg;
      logic       retire;
      logic       illegal;
   } outs_t;

   localparam int C_ILL = 0, C_LDUR = 1, C_STUR = 2, C_ADD = 3, C_SUB = 4, C_AND = 5,
                  C_ORR = 6, C_ADDI = 7, C_SUBI = 8, C_CBZ = 9, C_B = 10;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [10:0] opcode;
   logic        zero;
   logic        ir_write, pc_write, pc_src, reg2loc, alusrc, reg_write, mem2reg, retire, illegal;
   logic [3:0]  aluctrl;
   logic [2:0]  signop;
   logic [31:0] instr_count;

   multicycle_sequencer_if mif ();

   multicycle_sequencer dut (
      .CLK         (CLK),
      .resetl      (resetl),
      .opcode      (opcode),
      .zero        (zero),
      .mem         (mif),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .reg2loc     (reg2loc),
      .alusrc      (alusrc),
      .aluctrl     (aluctrl),
      .signop      (signop),
      .reg_write   (reg_write),
      .mem2reg     (mem2reg),
      .retire      (retire),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- behavioural model ----------------
   logic [10:0] prog[$];
   logic [10:0] m_op = '0;
   int          m_cls = C_ILL;
   string       m_seq = "F";
   int          m_idx = 0;
   int          m_done = 0;
   logic [31:0] m_count = '0;

   // DUT-observed per-instruction measurements
   int   d_len = 0, d_hold = 0, d_last_len = 0, d_last_hold = 0;
   logic d_pcs = 1'b0, d_last_pcs = 1'b0;

   // stimulus controls
   bit   rdy_rand = 1'b0, zero_rand = 1'b0;
   logic zero_fix = 1'b0;
   int   waits_left = 0;

   function automatic int classify(logic [10:0] op);
      casez (op)
         11'b11111000010: return C_LDUR;
         11'b11111000000: return C_STUR;
         11'b10001011000: return C_ADD;
         11'b11001011000: return C_SUB;
         11'b10001010000: return C_AND;
         11'b10101010000: return C_ORR;
         11'b1001000100?: return C_ADDI;
         11'b1101000100?: return C_SUBI;
         11'b10110100???: return C_CBZ;
         11'b000101?????: return C_B;
         default:         return C_ILL;
      endcase
   endfunction

   // Phases an instruction walks through; F and M stretch while memory waits.
   function automatic string seq_of(int c);
      case (c)
         C_ILL:        return "FD";
         C_B, C_CBZ:   return "FDE";
         C_STUR:       return "FDEM";
         C_LDUR:       return "FDEMW";
         default:      return "FDEW";
      endcase
   endfunction

   function automatic outs_t model_outs(byte ph, int c, logic z, logic rdy);
      outs_t o;
      o = '0;
      case (ph)
         "F": begin
            o.mem_req = 1'b1;
            o.ir_write = rdy;
            o.pc_write = rdy;
         end
         "D": o.illegal = (c == C_ILL);
         "E": case (c)
            C_ADD:  o.aluctrl = 4'b0010;
            C_SUB:  o.aluctrl = 4'b0110;
            C_AND:  o.aluctrl = 4'b0000;
            C_ORR:  o.aluctrl = 4'b0001;
            C_ADDI: begin o.aluctrl = 4'b0010; o.alusrc = 1'b1; o.signop = 3'b000; end
            C_SUBI: begin o.aluctrl = 4'b0110; o.alusrc = 1'b1; o.signop = 3'b000; end
            C_LDUR: begin o.aluctrl = 4'b0010; o.alusrc = 1'b1; o.signop = 3'b001; end
            C_STUR: begin o.aluctrl = 4'b0010; o.alusrc = 1'b1; o.signop = 3'b001; o.reg2loc = 1'b1; end
            C_CBZ: begin
               o.reg2loc = 1'b1; o.aluctrl = 4'b0111; o.signop = 3'b011;
               o.pc_write = z; o.pc_src = z; o.retire = 1'b1;
            end
            C_B: begin o.signop = 3'b010; o.pc_write = 1'b1; o.pc_src = 1'b1; o.retire = 1'b1; end
            default: ;
         endcase
         "M": begin
            o.mem_req = 1'b1;
            o.iord    = 1'b1;
            o.mem_we  = (c == C_STUR);
            o.retire  = (c == C_STUR) && rdy;
         end
         "W": begin
            o.reg_write = 1'b1;
            o.mem2reg   = (c == C_LDUR);
            o.retire    = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

   function automatic logic [10:0] rand_op();
      logic [10:0] r;
      r = 11'($urandom);
      case ($urandom_range(0, 10))
         0:  return 11'h7C2;
         1:  return 11'h7C0;
         2:  return 11'h458;
         3:  return 11'h658;
         4:  return 11'h450;
         5:  return 11'h550;
         6:  return {10'h244, r[0]};
         7:  return {10'h344, r[0]};
         8:  return {8'hB4, r[2:0]};
         9:  return {6'h05, r[4:0]};
         default: return r;
      endcase
   endfunction

   // ---------------- per-cycle compare process ----------------
   outs_t exp_o, act_o;
   byte   ph;

   always @(negedge CLK) begin
      ph    = m_seq[m_idx];
      exp_o = resetl ? '0 : model_outs(ph, m_cls, zero, mif.mem_ready);
      act_o = {mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write, pc_src, reg2loc, alusrc,
               aluctrl, signop, reg_write, mem2reg, retire, illegal};
      n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL strobes @%0t phase=%c op=%h: got %h want %h", $time, ph, m_op, act_o, exp_o);
      end
      n_cmp++;
      if (instr_count !== m_count) begin
         n_bad++;
         $display("FAIL instr_count @%0t: got %h want %h", $time, instr_count, m_count);
      end

      if (resetl) begin
         m_idx   = 0;
         m_count = '0;
         d_len = 0; d_hold = 0; d_pcs = 1'b0;
      end else begin
         if (exp_o.retire) m_count = m_count + 32'd1;
         if (ph == "F") begin
            if (mif.mem_ready) begin
               m_op  = (prog.size() != 0) ? prog.pop_front() : rand_op();
               m_cls = classify(m_op);
               m_seq = seq_of(m_cls);
               m_idx = 1;
            end
         end else if (ph == "M" && !mif.mem_ready) begin
            // waiting on memory
         end else if (m_idx == m_seq.len() - 1) begin
            m_idx = 0;
            m_done++;
         end else begin
            m_idx++;
         end

         d_len++;
         if (mif.mem_req && mif.iord) d_hold++;
         if (pc_src) d_pcs = 1'b1;
         if (retire || illegal) begin
            d_last_len = d_len; d_last_hold = d_hold; d_last_pcs = d_pcs;
            d_len = 0; d_hold = 0; d_pcs = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
      opcode = m_op;
      if (rdy_rand) begin
         mif.mem_ready = ($urandom_range(0, 3) != 0);
      end else if (m_seq[m_idx] == "M" && waits_left > 0) begin
         mif.mem_ready = 1'b0;
         waits_left--;
      end else begin
         mif.mem_ready = 1'b1;
      end
      zero = zero_rand ? 1'($urandom_range(0, 1)) : zero_fix;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_done(string name);
      int start;
      int n;
      start = m_done;
      n = 0;
      while (m_done == start && n < 60) begin
         cyc();
         n++;
      end
      if (m_done == start) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: got no completion want completion within 60 cycles", name);
      end
   endtask

   task automatic wait_phase(string name, byte want, logic [10:0] op);
      int n;
      n = 0;
      while (!(m_seq[m_idx] == want && m_op == op) && n < 60) begin
         cyc();
         n++;
      end
      if (n >= 60) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: got no phase %c want phase %c", name, m_seq[m_idx], want);
      end
   endtask

   initial begin
      resetl = 1'b1;
      opcode = '0;
      zero   = 1'b0;
      mif.mem_ready = 1'b1;

      // reset held for three cycles
      for (int i = 0; i < 3; i++) cyc();
      #2;
      chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst_count", instr_count, 32'd0);

      // ADD with zero-wait memory
      prog.push_back(11'h458);
      cyc();
      resetl = 1'b0;
      #2;
      chk("rel_mem_req", {31'd0, mif.mem_req}, 32'd1);
      chk("rel_iord", {31'd0, mif.iord}, 32'd0);
      wait_done("add");
      chk("add_len", d_last_len, 32'd4);
      chk("add_count", instr_count, 32'd1);

      // LDUR with two memory wait cycles
      waits_left = 2;
      prog.push_back(11'h7C2);
      wait_done("ldur");
      chk("ldur_len", d_last_len, 32'd7);
      chk("ldur_hold", d_last_hold, 32'd3);
      chk("ldur_count", instr_count, 32'd2);

      // CBZ taken
      zero_fix = 1'b1;
      prog.push_back(11'h5A3);
      wait_done("cbz1");
      chk("cbz1_len", d_last_len, 32'd3);
      chk("cbz1_pcsrc", {31'd0, d_last_pcs}, 32'd1);
      chk("cbz1_count", instr_count, 32'd3);

      // CBZ not taken
      zero_fix = 1'b0;
      prog.push_back(11'h5A7);
      wait_done("cbz0");
      chk("cbz0_len", d_last_len, 32'd3);
      chk("cbz0_pcsrc", {31'd0, d_last_pcs}, 32'd0);
      chk("cbz0_count", instr_count, 32'd4);

      // illegal opcode
      prog.push_back(11'h000);
      wait_done("ill");
      chk("ill_len", d_last_len, 32'd2);
      chk("ill_count", instr_count, 32'd4);
      #2;
      chk("ill_next_fetch", {30'd0, mif.mem_req, mif.iord}, 32'd2);

      // counter wrap on a retiring B
      prog.push_back(11'h0A5);
      wait_phase("b_decode", "D", 11'h0A5);
      force dut.r_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      cyc();
      release dut.r_count;
      wait_done("b_wrap");
      chk("wrap_count", instr_count, 32'd0);

      // reset during a STUR memory wait
      waits_left = 5;
      prog.push_back(11'h7C0);
      wait_phase("stur_mem", "M", 11'h7C0);
      cyc();
      resetl = 1'b1;
      #2;
      chk("rstm_mem_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rstm_mem_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rstm_retire", {31'd0, retire}, 32'd0);
      waits_left = 0;
      cyc();
      resetl = 1'b0;
      #2;
      chk("rstm_fetch", {29'd0, mif.mem_req, mif.iord, mif.mem_we}, 32'd4);

      // randomized traffic with random memory waits, zero flag and resets
      rdy_rand  = 1'b1;
      zero_rand = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         cyc();
         resetl = ($urandom_range(0, 149) == 0);
      end
      cyc();
      resetl = 1'b0;
      for (int i = 0; i < 10; i++) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
